axi_burst_master: RTL and testbench
===================================

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 SHALL have parameter C_M_AXI_ID_WIDTH, default 2, the AXI ID width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, the data width; legal values are 32 or 64.
REQ-003 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 6, the byte address width.
REQ-004 SHALL have M_AXI_ACLK, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have M_AXI_ARESETN, input, 1, an asynchronous active-low reset.
REQ-006 SHALL have cmd_valid/cmd_ready, in/out, 1/1, the command handshake.
REQ-007 SHALL have cmd_write, input, 1: 1 = write burst, 0 = read burst.
REQ-008 SHALL have cmd_addr, input, ADDR_WIDTH, the burst start byte address.
REQ-009 SHALL have cmd_len, input, 8, the beat count minus 1.
REQ-010 SHALL have cmd_id, input, ID_WIDTH, the transaction ID.
REQ-011 SHALL have wr_data/wr_valid/wr_ready, in/in/out, DATA_WIDTH/1/1, the write-data source stream.
REQ-012 SHALL have rd_data/rd_last/rd_valid/rd_ready, out/out/out/in, DATA_WIDTH/1/1/1, the read-data sink stream.
REQ-013 SHALL have done_valid/done_ready, out/in, 1/1, the completion handshake.
REQ-014 SHALL have done_resp (out, 2) and done_write (out, 1): the completion status and the direction.
REQ-015 SHALL have full AXI4 master AW/W/B/AR/R channels prefixed M_AXI_ (AWID, AWADDR, AWLEN[8], AWSIZE[3], AWBURST[2], AWVALID, AWREADY, WDATA, WSTRB, WLAST, WVALID, WREADY, BID, BRESP, BVALID, BREADY, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID, RREADY), with widths per the parameters.

Function
REQ-016 SHALL implement FSM states IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE, with exactly one transaction outstanding.
REQ-017 In IDLE, SHALL hold cmd_ready=1 and all other valids/readies at 0.
REQ-018 On a cmd handshake, SHALL latch the command and go to WADDR (cmd_write=1) or RADDR (cmd_write=0) on the next cycle.
REQ-019 On AW and AR, SHALL drive: ADDR = latched address with the low log2(DW/8) bits forced to 0; LEN = cmd_len; SIZE = log2(DW/8); BURST = 2'b01 (INCR); ID = cmd_id.
REQ-020 SHALL hold AWVALID/ARVALID with stable payload until the READY handshake, then move to WDATA/RDATA.
REQ-021 No W beat SHALL be issued before the AW handshake completes.
REQ-022 In WDATA, SHALL drive WVALID=wr_valid, wr_ready=WREADY, WDATA=wr_data (combinational) and WSTRB all ones.
REQ-023 SHALL keep an 8-bit beat counter, cleared at command accept and incremented on each W or R handshake.
REQ-024 SHALL assert WLAST exactly when beat counter == latched len; len=0 gives WLAST on the first beat.
REQ-025 On the last W handshake, SHALL go to WRESP and assert BREADY=1 there.
REQ-026 On a B handshake, SHALL go to DONE with done_resp=BRESP, or 2'b10 if BID != latched id.
REQ-027 In RDATA, SHALL drive rd_valid=RVALID, RREADY=rd_ready, rd_data=RDATA and rd_last=RLAST (combinational).
REQ-028 SHALL accumulate the read status as the maximum RRESP seen across beats (sticky).
REQ-029 On an R handshake with RLAST=1, SHALL go to DONE.
REQ-030 The read status SHALL be forced to 2'b10 if RLAST arrives with beat counter != len, or if any RID != latched id.
REQ-031 If RLAST is absent on beat len, SHALL stay in RDATA and flag 2'b10.
REQ-032 In DONE, SHALL hold done_valid=1 with stable done_resp/done_write until done_ready, then return to IDLE.
REQ-033 Accept-to-AWVALID/ARVALID latency SHALL be 1 cycle; last-beat-to-done_valid latency SHALL be 1 cycle.
REQ-034 Address wrap beyond 2^ADDR_WIDTH SHALL NOT be checked; it is passed to the slave unchanged.

Reset
REQ-035 On M_AXI_ARESETN=0, SHALL immediately (asynchronously) return to IDLE.
REQ-036 During reset, all AXI VALID/READY, cmd_ready, wr_ready, rd_valid and done_valid SHALL be 0; counters, status and latched fields SHALL be 0.
REQ-037 cmd_ready SHALL rise on the first clock edge after reset release.
REQ-038 A reset mid-burst SHALL abandon the transaction with no done_valid issued.

Verification
REQ-039 Write addr=0x10, len=3, id=1, slave AWREADY after 2 cycles -> AWADDR=0x10, AWLEN=3, AWSIZE=2, AWBURST=1, 4 W beats, WLAST on the 4th, done_resp=0, done_write=1.
REQ-040 Read addr=0x13, len=0 -> ARADDR=0x10, a single R beat with rd_last=1, done_resp=0.
REQ-041 Write len=7 with wr_valid toggling every other cycle and WREADY random -> exactly 8 W beats with data order preserved, followed by BREADY handshake.
REQ-042 Read len=3 with rd_ready stalled 3 cycles mid-burst -> RREADY low during the stall, 4 beats delivered, rd_last only on the 4th.
REQ-043 Read len=3 where the slave returns RLAST on beat 2 or RRESP=2 on one beat -> done_resp=2'b10.
REQ-044 Assert reset during WDATA beat 2 -> all valids 0 immediately, FSM in IDLE, cmd_ready=1 on the first edge after release.

Source files
------------

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master: a command starts one INCR write or read burst,
// data moves through simple valid/ready streams, and a done handshake reports status.
module axi_burst_master #(
    parameter int C_M_AXI_ID_WIDTH   = 2,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 6
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]                      cmd_len,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     cmd_id,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data,
    input  logic                            wr_valid,
    output logic                            wr_ready,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data,
    output logic                            rd_last,
    output logic                            rd_valid,
    input  logic                            rd_ready,

    output logic                            done_valid,
    input  logic                            done_ready,
    output logic [1:0]                      done_resp,
    output logic                            done_write,

    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW        = C_M_AXI_ADDR_WIDTH;
    localparam int SIZE_LOG2 = $clog2(C_M_AXI_DATA_WIDTH / 8);
    localparam logic [AW-1:0] ALIGN_MASK = {AW{1'b1}} << SIZE_LOG2;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WDATA,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [AW-1:0]                  addr_q, addr_d;
    logic [7:0]                     len_q, len_d;
    logic [C_M_AXI_ID_WIDTH-1:0]    id_q, id_d;
    logic                           write_q, write_d;
    logic [7:0]                     beat_q, beat_d;
    logic [1:0]                     resp_q, resp_d;
    logic                           live_q;
    logic                           last_beat;

    assign last_beat = (beat_q == len_q);

    // Address/ID payload comes straight from the latched command, so it is stable while VALID waits.
    assign M_AXI_AWID    = id_q;
    assign M_AXI_AWADDR  = addr_q & ALIGN_MASK;
    assign M_AXI_AWLEN   = len_q;
    assign M_AXI_AWSIZE  = 3'(SIZE_LOG2);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_ARID    = id_q;
    assign M_AXI_ARADDR  = addr_q & ALIGN_MASK;
    assign M_AXI_ARLEN   = len_q;
    assign M_AXI_ARSIZE  = 3'(SIZE_LOG2);
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_WDATA   = wr_data;
    assign M_AXI_WSTRB   = '1;
    assign rd_data       = M_AXI_RDATA;
    assign done_resp     = resp_q;
    assign done_write    = write_q;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            write_q <= 1'b0;
            beat_q  <= '0;
            resp_q  <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            write_q <= write_d;
            beat_q  <= beat_d;
            resp_q  <= resp_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        id_d          = id_q;
        write_d       = write_q;
        beat_d        = beat_q;
        resp_d        = resp_q;
        cmd_ready     = 1'b0;
        wr_ready      = 1'b0;
        rd_valid      = 1'b0;
        rd_last       = 1'b0;
        done_valid    = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_WLAST   = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // live_q holds cmd_ready low until the first edge after reset release
                cmd_ready = live_q;
                if (cmd_valid && live_q) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    id_d    = cmd_id;
                    write_d = cmd_write;
                    beat_d  = '0;
                    resp_d  = '0;
                    state_d = cmd_write ? S_WADDR : S_RADDR;
                end
            end
            S_WADDR: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) state_d = S_WDATA;
            end
            S_WDATA: begin
                M_AXI_WVALID = wr_valid;
                wr_ready     = M_AXI_WREADY;
                M_AXI_WLAST  = last_beat;
                if (wr_valid && M_AXI_WREADY) begin
                    beat_d = beat_q + 8'd1;
                    if (last_beat) state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    resp_d  = (M_AXI_BID != id_q) ? RESP_SLVERR : M_AXI_BRESP;
                    state_d = S_DONE;
                end
            end
            S_RADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_d = S_RDATA;
            end
            S_RDATA: begin
                rd_valid     = M_AXI_RVALID;
                M_AXI_RREADY = rd_ready;
                rd_last      = M_AXI_RLAST;
                if (M_AXI_RVALID && rd_ready) begin
                    beat_d = beat_q + 8'd1;
                    resp_d = (M_AXI_RRESP > resp_q) ? M_AXI_RRESP : resp_q;
                    // RLAST early, late or missing on the final beat, or a foreign ID, marks the burst bad
                    if ((M_AXI_RID != id_q) || (M_AXI_RLAST != last_beat)) resp_d = RESP_SLVERR;
                    if (M_AXI_RLAST) state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_valid = 1'b1;
                if (done_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Randomized bench for axi_burst_master: bench acts as command source, data streams and AXI slave,
// and checks beats and completion status against expectations derived from the burst plan.
module tb_axi_burst_master;

    localparam int IDW = 2;
    localparam int DW  = 32;
    localparam int AW  = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]  cmd_addr;
    logic [7:0]     cmd_len;
    logic [IDW-1:0] cmd_id;
    logic [DW-1:0]  wr_data;
    logic           wr_valid, wr_ready;
    logic [DW-1:0]  rd_data;
    logic           rd_last, rd_valid, rd_ready;
    logic           done_valid, done_ready, done_write;
    logic [1:0]     done_resp;
    logic [IDW-1:0] awid, arid, bid, rid;
    logic [AW-1:0]  awaddr, araddr;
    logic [7:0]     awlen, arlen;
    logic [2:0]     awsize, arsize;
    logic [1:0]     awburst, arburst, bresp, rresp;
    logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic           arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0]  wdata, rdata;
    logic [DW/8-1:0] wstrb;

    axi_burst_master #(
        .C_M_AXI_ID_WIDTH(IDW), .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done_valid(done_valid), .done_ready(done_ready), .done_resp(done_resp), .done_write(done_write),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] all_handshakes();
        return {awvalid, wvalid, bready, arvalid, rready, cmd_ready, wr_ready, rd_valid, done_valid};
    endfunction

    // Called at posedge+1 right after the edge that completed the last beat / B response.
    task automatic finish_done(input logic [1:0] exp_resp, input logic exp_write);
        int n;
        @(negedge clk);
        chk("done_valid", 64'(done_valid), 64'(1));
        chk("done_resp", 64'(done_resp), 64'(exp_resp));
        chk("done_write", 64'(done_write), 64'(exp_write));
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            tick();
            @(negedge clk);
            chk("done_hold", 64'(done_valid), 64'(1));
            chk("done_resp_stable", 64'(done_resp), 64'(exp_resp));
        end
        tick();
        done_ready = 1'b1;
        @(negedge clk);
        chk("done_valid_hs", 64'(done_valid), 64'(1));
        tick();
        done_ready = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("done_clear", 64'(done_valid), 64'(0));
    endtask

    task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [IDW-1:0] id);
        tick();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
        @(negedge clk);
        chk("cmd_ready", 64'(cmd_ready), 64'(1));
    endtask

    task automatic run_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IDW-1:0] id,
                             input int aw_delay, input bit toggle, input logic [1:0] b_resp,
                             input bit bad_bid, input int rst_beat);
        logic [DW-1:0] wdat [256];
        logic [AW-1:0] exp_addr;
        int idx, cyc;
        for (int i = 0; i < 256; i++) wdat[i] = $urandom;
        exp_addr = {addr[AW-1:2], 2'b00};
        issue_cmd(1'b1, addr, len, id);
        tick();
        cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = wdat[0]; awready = (aw_delay == 0);
        @(negedge clk);
        chk("awvalid_lat", 64'(awvalid), 64'(1));
        chk("awaddr", 64'(awaddr), 64'(exp_addr));
        chk("awlen", 64'(awlen), 64'(len));
        chk("awsize", 64'(awsize), 64'(2));
        chk("awburst", 64'(awburst), 64'(1));
        chk("awid", 64'(awid), 64'(id));
        chk("w_before_aw", 64'(wvalid), 64'(0));
        for (int i = 1; i <= aw_delay; i++) begin
            tick();
            awready = (i == aw_delay);
            @(negedge clk);
            chk("awvalid_hold", 64'(awvalid), 64'(1));
            chk("awaddr_hold", 64'(awaddr), 64'(exp_addr));
            chk("w_before_aw", 64'(wvalid), 64'(0));
        end
        tick();
        awready = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx <= int'(len) && cyc < 400) begin
            wr_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            wr_data  = wdat[idx];
            wready   = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (idx == rst_beat) begin
                rst_n = 1'b0;
                #1;
                chk("rst_handshakes_low", 64'(all_handshakes()), 64'(0));
                wr_valid = 1'b0; wready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                chk("rst_hold_low", 64'(all_handshakes()), 64'(0));
                chk("rst_fields_zero", 64'({awaddr, awlen, awid, done_resp}), 64'(0));
                rst_n = 1'b1;
                @(negedge clk);
                chk("cmd_ready_before_edge", 64'(cmd_ready), 64'(0));
                tick();
                @(negedge clk);
                chk("cmd_ready_first_edge", 64'(cmd_ready), 64'(1));
                for (int i = 0; i < 4; i++) begin
                    tick();
                    @(negedge clk);
                    chk("no_done_after_rst", 64'({done_valid, awvalid, wvalid}), 64'(0));
                end
                return;
            end
            chk("wvalid_pass", 64'(wvalid), 64'(wr_valid));
            chk("wr_ready_pass", 64'(wr_ready), 64'(wready));
            if (wvalid && wready) begin
                chk("wdata", 64'(wdata), 64'(wdat[idx]));
                chk("wstrb", 64'(wstrb), 64'(4'hF));
                chk("wlast", 64'(wlast), 64'(idx == int'(len)));
                idx++;
            end
            tick();
            cyc++;
        end
        chk("w_beats", 64'(idx), 64'(int'(len) + 1));
        wr_valid = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bresp = b_resp; bid = bad_bid ? (id ^ 2'b01) : id;
        @(negedge clk);
        chk("bready", 64'(bready), 64'(1));
        chk("no_w_after_last", 64'(wvalid), 64'(0));
        tick();
        bvalid = 1'b0;
        finish_done(bad_bid ? 2'b10 : b_resp, 1'b1);
    endtask

    // rlast_at: beat index carrying RLAST; bad_rid_at / err_at: beat with foreign RID / RRESP=2 (-1 none)
    task automatic run_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IDW-1:0] id,
                            input int ar_delay, input bit stall, input int rlast_at,
                            input int bad_rid_at, input bit rand_resp, input int err_at);
        logic [DW-1:0] rdat [256];
        logic [1:0]    rr [256];
        logic [1:0]    exp_resp;
        int k, cyc, lastcnt;
        bit fin;
        for (int i = 0; i < 256; i++) begin
            rdat[i] = $urandom;
            rr[i]   = rand_resp ? 2'($urandom_range(0, 2)) : 2'b00;
        end
        if (err_at >= 0) rr[err_at] = 2'b10;
        exp_resp = 2'b00;
        for (int i = 0; i <= rlast_at; i++) if (rr[i] > exp_resp) exp_resp = rr[i];
        if (rlast_at != int'(len) || (bad_rid_at >= 0 && bad_rid_at <= rlast_at)) exp_resp = 2'b10;

        issue_cmd(1'b0, addr, len, id);
        tick();
        cmd_valid = 1'b0; arready = (ar_delay == 0);
        @(negedge clk);
        chk("arvalid_lat", 64'(arvalid), 64'(1));
        chk("araddr", 64'(araddr), 64'({addr[AW-1:2], 2'b00}));
        chk("arlen", 64'(arlen), 64'(len));
        chk("arsize_burst_id", 64'({arsize, arburst, arid}), 64'({3'd2, 2'b01, id}));
        for (int i = 1; i <= ar_delay; i++) begin
            tick();
            arready = (i == ar_delay);
            @(negedge clk);
            chk("arvalid_hold", 64'(arvalid), 64'(1));
        end
        tick();
        arready = 1'b0;
        k = 0; cyc = 0; fin = 1'b0; lastcnt = 0;
        while (!fin && cyc < 600) begin
            rvalid   = stall ? 1'b1 : ($urandom_range(0, 3) != 0);
            rdata    = rdat[k];
            rresp    = rr[k];
            rlast    = (k == rlast_at);
            rid      = (k == bad_rid_at) ? (id ^ 2'b01) : id;
            rd_ready = stall ? !(cyc >= 3 && cyc < 6) : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("rd_valid_pass", 64'(rd_valid), 64'(rvalid));
            chk("rready_pass", 64'(rready), 64'(rd_ready));
            if (rvalid && rready) begin
                chk("rd_data", 64'(rd_data), 64'(rdat[k]));
                chk("rd_last", 64'(rd_last), 64'(k == rlast_at));
                if (rd_last) lastcnt++;
                if (rlast) fin = 1'b1;
                k++;
            end
            tick();
            cyc++;
        end
        rvalid = 1'b0; rlast = 1'b0;
        chk("r_beats", 64'(k), 64'(rlast_at + 1));
        chk("rd_last_count", 64'(lastcnt), 64'(1));
        finish_done(exp_resp, 1'b0);
    endtask

    initial begin
        int len, r, rl, bad;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        wr_data = '0; wr_valid = 0; rd_ready = 0; done_ready = 0;
        awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0; arready = 0;
        rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
        rst_n = 1'b0;
        #2;
        chk("reset_handshakes_low", 64'(all_handshakes()), 64'(0));
        chk("reset_fields_zero", 64'({awaddr, awlen, arid, done_resp, done_write}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_before_edge", 64'(cmd_ready), 64'(0));
        tick();
        @(negedge clk);
        chk("cmd_ready_first_edge", 64'(cmd_ready), 64'(1));

        run_write(6'h10, 8'd3, 2'd1, 2, 1'b0, 2'b00, 1'b0, -1);
        run_read (6'h13, 8'd0, 2'd2, 0, 1'b0, 0, -1, 1'b0, -1);
        run_write(6'h20, 8'd7, 2'd3, 1, 1'b1, 2'b00, 1'b0, -1);
        run_read (6'h04, 8'd3, 2'd1, 1, 1'b1, 3, -1, 1'b0, -1);
        run_read (6'h08, 8'd3, 2'd0, 0, 1'b0, 2, -1, 1'b0, -1);
        run_read (6'h08, 8'd3, 2'd0, 0, 1'b0, 3, -1, 1'b0, 1);
        run_read (6'h0c, 8'd2, 2'd2, 0, 1'b0, 3, -1, 1'b0, -1);
        run_read (6'h30, 8'd3, 2'd3, 0, 1'b0, 3, 1, 1'b0, -1);
        run_read (6'h3f, 8'd5, 2'd1, 0, 1'b0, 5, -1, 1'b1, -1);
        run_write(6'h3d, 8'd0, 2'd2, 0, 1'b0, 2'b00, 1'b1, -1);
        run_write(6'h01, 8'd1, 2'd0, 3, 1'b0, 2'b01, 1'b0, -1);
        run_write(6'h00, 8'd3, 2'd2, 0, 1'b0, 2'b00, 1'b0, 2);
        run_read (6'h14, 8'd1, 2'd1, 0, 1'b0, 1, -1, 1'b0, -1);

        for (int t = 0; t < 16; t++) begin
            len = $urandom_range(0, 15);
            r   = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 1) begin
                run_write(6'($urandom), 8'(len), 2'($urandom), $urandom_range(0, 3), (r == 0),
                          2'($urandom_range(0, 2)), (r == 1), -1);
            end else begin
                rl  = (r == 0 && len > 0) ? len - 1 : ((r == 1) ? len + 1 : len);
                bad = (r == 2) ? $urandom_range(0, len) : -1;
                run_read(6'($urandom), 8'(len), 2'($urandom), $urandom_range(0, 3), 1'b0, rl, bad,
                         1'b1, -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
